instr_fetch: RTL and testbench

- Fetch stage of the 9-bit CPU; feeds the decode stage directly.
- Holds the program counter and drives a synchronous instruction ROM with 1-cycle read latency.
- Buffers returned 9-bit words (op[8:4], operand[3:0]) and presents them to decode with a valid/ready handshake.
- Accepts redirects from execute (taken jizr/jnzr/bizr/bnzr/ljp*), and stops fetching after the `func done` instruction.

---
 rtl/instr_pack.sv | 25 ++
 rtl/fetch_skid_buf.sv | 76 +++++++
 rtl/instr_fetch.sv | 125 ++++++++++++
 tb/tb_instr_fetch.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/instr_pack.sv
// instr_pack: shared definitions for the 9-bit CPU front end.
//   fetch_state : fetch sequencer states (IDLE, RUN, HALT).
//   OP_MSB/OP_LSB : opcode field slice of a 9-bit word (op[8:4], operand[3:0]).
//   DONE_INSTR  : `func done` (op func, operand done) = 9'h1FF; stops fetch.
//   is_done()   : true when a word is the done instruction.
package instr_pack;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state;

    localparam int         OP_MSB     = 8;
    localparam int         OP_LSB     = 4;
    localparam logic [4:0] OP_FUNC    = 5'h1F;
    localparam logic [3:0] FUNC_DONE  = 4'hF;
    localparam logic [8:0] DONE_INSTR = {OP_FUNC, FUNC_DONE};

    function automatic logic is_done(input logic [8:0] w);
        return (w[OP_MSB:OP_LSB] == DONE_INSTR[OP_MSB:OP_LSB]) &&
               (w[OP_LSB-1:0]    == DONE_INSTR[OP_LSB-1:0]);
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: two-entry (out + skid) buffer between the ROM return path
// and decode. Each entry holds a 9-bit word plus its PC tag.
//   clk, rst_n       : clock, synchronous active-low reset
//   flush            : drop both entries (redirect)
//   push/push_instr/push_pc : returning ROM word and its address
//   pop              : decode accepted the out entry this cycle
//   out_valid/out_instr/out_pc : entry presented to decode
//   skid_valid       : second entry occupied (upstream must stop issuing)
module fetch_skid_buf #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  logic [8:0]      push_instr,
    input  logic [PC_W-1:0] push_pc,
    input  logic            pop,
    output logic            out_valid,
    output logic [8:0]      out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic            skid_valid
);

    logic [8:0]      skid_instr;
    logic [PC_W-1:0] skid_pc;
    logic            take;

    assign take = pop & out_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (take) begin
            if (skid_valid) begin
                // older skid word advances; a returning word backfills the skid
                out_instr  <= skid_instr;
                out_pc     <= skid_pc;
                skid_valid <= push;
                if (push) begin
                    skid_instr <= push_instr;
                    skid_pc    <= push_pc;
                end
            end else begin
                out_valid <= push;
                if (push) begin
                    out_instr <= push_instr;
                    out_pc    <= push_pc;
                end
            end
        end else if (push) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                out_instr <= push_instr;
                out_pc    <= push_pc;
            end else begin
                skid_valid <= 1'b1;
                skid_instr <= push_instr;
                skid_pc    <= push_pc;
            end
        end
    end

    // issue throttling upstream guarantees room for every returning word
    a_no_drop: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && !take && out_valid && skid_valid));

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the 9-bit CPU. Holds the PC, reads a
// synchronous ROM (1-cycle latency) and hands words to decode via
// valid/ready. Redirects flush and refetch; the done word halts fetch.
//   clk, rst_n           : clock, synchronous active-low reset
//   start                : leave IDLE (or restart from HALT) at RESET_PC
//   imem_addr/imem_rd    : ROM read request
//   imem_data            : ROM word, valid the cycle after imem_rd
//   dec_valid/dec_instr/dec_pc/dec_ready : decode handshake
//   redirect/redirect_pc : flush and refetch from redirect_pc
//   halted               : the done word has been consumed by decode
// Optional (macro FETCH_PERF_EN): stall_cnt, fetch_cnt saturating counters.
module instr_fetch
    import instr_pack::*;
#(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [8:0]      imem_data,
    output logic            dec_valid,
    output logic [8:0]      dec_instr,
    output logic [PC_W-1:0] dec_pc,
    input  logic            dec_ready,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [15:0]     stall_cnt,
    output logic [15:0]     fetch_cnt,
`endif
    output logic            halted
);

    fetch_state      state, state_nxt;
    logic [PC_W-1:0] pc_q;
    logic            inflight;
    logic [PC_W-1:0] inflight_pc;
    logic            skid_valid;
    logic            issue;
    logic            pop;
    logic            done_ret;
    logic            redir_take;
    logic [PC_W-1:0] redir_tgt;

    assign pop      = dec_valid & dec_ready;
    assign done_ret = inflight & is_done(imem_data);

    // start out of IDLE or HALT is treated as a redirect to RESET_PC;
    // an explicit redirect wins over start
    assign redir_take = redirect | (start & (state != RUN));
    assign redir_tgt  = redirect ? redirect_pc : RESET_PC;

    assign imem_addr = pc_q;
    assign imem_rd   = issue;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            RUN: begin
                // a word in flight that would land in the skid uses the last slot
                issue = !skid_valid && !(inflight && dec_valid && !dec_ready);
                if (done_ret) state_nxt = HALT;
            end
            default: ;
        endcase
        if (redir_take) state_nxt = RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            halted      <= 1'b0;
        end else if (redir_take) begin
            pc_q     <= redir_tgt;
            inflight <= 1'b0;
            halted   <= 1'b0;
        end else begin
            if (issue) pc_q <= pc_q + 1'b1;
            // the read issued alongside a returning done word is younger: squash it
            inflight    <= issue & ~done_ret;
            inflight_pc <= pc_q;
            if (pop && is_done(dec_instr)) halted <= 1'b1;
        end
    end

    fetch_skid_buf #(.PC_W(PC_W)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redir_take),
        .push       (inflight),
        .push_instr (imem_data),
        .push_pc    (inflight_pc),
        .pop        (pop),
        .out_valid  (dec_valid),
        .out_instr  (dec_instr),
        .out_pc     (dec_pc),
        .skid_valid (skid_valid)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            stall_cnt <= '0;
            fetch_cnt <= '0;
        end else begin
            if (state == RUN && dec_valid && !dec_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 1'b1;
            if (issue && fetch_cnt != 16'hFFFF)
                fetch_cnt <= fetch_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    localparam int PC_W = 10;

    logic            clk = 1'b0;
    logic            rst_n, start, imem_rd, dec_valid, dec_ready, redirect, halted;
    logic [PC_W-1:0] imem_addr, dec_pc, redirect_pc;
    logic [8:0]      imem_data = '0;
    logic [8:0]      dec_instr;
`ifdef FETCH_PERF_EN
    logic [15:0]     stall_cnt, fetch_cnt;
`endif

    logic [8:0] rom [0:1023];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_rd) imem_data <= rom[imem_addr];

    instr_fetch #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_data   (imem_data),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
`ifdef FETCH_PERF_EN
        .stall_cnt   (stall_cnt),
        .fetch_cnt   (fetch_cnt),
`endif
        .halted      (halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // wait (bounded) for a word, check it against the ROM model, consume it
    task automatic expect_word(input logic [PC_W-1:0] pc);
        dec_ready = 1'b1;
        for (int i = 0; i < 8 && !dec_valid; i++) tick();
        chk($sformatf("valid@%0h", pc), 32'(dec_valid), 32'd1);
        chk($sformatf("dec_pc@%0h", pc), 32'(dec_pc), 32'(pc));
        chk($sformatf("dec_instr@%0h", pc), 32'(dec_instr), 32'(rom[pc]));
        tick();
    endtask

    // called just after a start/redirect edge: first word two edges later
    task automatic chk_refill(input string tag, input logic [PC_W-1:0] pc);
        chk({tag, "_rd"}, 32'(imem_rd), 32'd1);
        chk({tag, "_addr"}, 32'(imem_addr), 32'(pc));
        chk({tag, "_v0"}, 32'(dec_valid), 32'd0);
        tick();
        chk({tag, "_v1"}, 32'(dec_valid), 32'd0);
        tick();
        chk({tag, "_v2"}, 32'(dec_valid), 32'd1);
        chk({tag, "_pc"}, 32'(dec_pc), 32'(pc));
    endtask

    task automatic do_redirect(input logic [PC_W-1:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
    endtask

    initial begin
        logic seen;
        for (int i = 0; i < 1024; i++) rom[i] = {1'b0, i[7:0]} ^ 9'h0A5;
        rom[0] = 9'h001; rom[1] = 9'h012; rom[2] = 9'h023; rom[3] = 9'h034;

        rst_n = 1'b0; start = 1'b0; dec_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick(); tick();
        chk("rst_valid", 32'(dec_valid), 32'd0);
        chk("rst_rd", 32'(imem_rd), 32'd0);
        chk("rst_instr", 32'(dec_instr), 32'd0);
        chk("rst_pc", 32'(dec_pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_rd", 32'(imem_rd), 32'd0);

        // basic stream from reset PC
        dec_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk_refill("start", 10'h000);
        for (int k = 0; k < 4; k++) expect_word(PC_W'(k));

        // stall three cycles with pc 4 presented
        dec_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_pc", 32'(dec_pc), 32'h4);
            chk("stall_instr", 32'(dec_instr), 32'(rom[4]));
            chk("stall_rd", 32'(imem_rd), 32'd0);
        end
        for (int k = 4; k < 8; k++) expect_word(PC_W'(k));

        // fill out + skid, then redirect
        dec_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("full_pc", 32'(dec_pc), 32'h8);
        chk("full_rd", 32'(imem_rd), 32'd0);
        dec_ready = 1'b1;
        do_redirect(10'h200);
        chk_refill("redir", 10'h200);
        expect_word(10'h200);
        expect_word(10'h201);

        // PC wrap
        do_redirect(10'h3FE);
        expect_word(10'h3FE);
        expect_word(10'h3FF);
        expect_word(10'h000);
        expect_word(10'h001);

        // done word at PC 5
        rom[5] = 9'h1FF;
        do_redirect(10'h003);
        expect_word(10'h003);
        expect_word(10'h004);
        chk("halted_before", 32'(halted), 32'd0);
        expect_word(10'h005);
        chk("halted_after", 32'(halted), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (dec_valid || imem_rd) seen = 1'b1;
            tick();
        end
        chk("halt_quiet", 32'(seen), 32'd0);
        chk("halted_hold", 32'(halted), 32'd1);

        start = 1'b1; tick(); start = 1'b0;
        chk("restart_halted", 32'(halted), 32'd0);
        chk_refill("restart", 10'h000);
        expect_word(10'h000);

        // reset mid-stream
        chk("pre_rst_valid", 32'(dec_valid), 32'd1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mid_rst_valid", 32'(dec_valid), 32'd0);
        chk("mid_rst_pc", 32'(dec_pc), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (imem_rd || dec_valid) seen = 1'b1;
            tick();
        end
        chk("mid_rst_idle", 32'(seen), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk_refill("start2", 10'h000);
        expect_word(10'h000);
        expect_word(10'h001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
